// File: rtl/ram_initiator.sv
// Request-side master for a single-port synchronous RAM: one request in, one response out.
// Build with RAM_INITIATOR_VERIFY_EN to add a read-back check after every write.
module ram_initiator #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3
`ifdef RAM_INITIATOR_VERIFY_EN
        ,
        VRD   = 3'd4,
        VWAIT = 3'd5
`endif
    } state_t;

    state_t              state_q, state_d;
    logic                lat_we_q, lat_we_d;
    logic                mem_ce_d, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;
    logic                rsp_valid_d, rsp_we_d;
    logic [DATA_W-1:0]   rsp_rdata_d;

`ifdef RAM_INITIATOR_VERIFY_EN
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   lat_wdata_q;

    assign rsp_err = rsp_err_q;

    // Expected read-back value; pure data, so no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid)
            lat_wdata_q <= req_wdata;
    end
`else
    assign rsp_err = 1'b0;
`endif

    assign req_ready = (state_q == IDLE) && !rst;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_we_q  <= 1'b0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
`ifdef RAM_INITIATOR_VERIFY_EN
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            lat_we_q  <= lat_we_d;
            mem_ce    <= mem_ce_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_we    <= rsp_we_d;
            rsp_rdata <= rsp_rdata_d;
`ifdef RAM_INITIATOR_VERIFY_EN
            rsp_err_q <= rsp_err_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_valid) state_d = ISSUE;
`ifdef RAM_INITIATOR_VERIFY_EN
            ISSUE: state_d = lat_we_q ? VRD : WAIT;
            VRD:   state_d = VWAIT;
            VWAIT: state_d = RESP;
`else
            ISSUE: state_d = lat_we_q ? RESP : WAIT;
`endif
            WAIT:  state_d = RESP;
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; address and write data hold when idle.
    always_comb begin
        lat_we_d    = lat_we_q;
        mem_ce_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        rsp_valid_d = rsp_valid;
        rsp_we_d    = rsp_we;
        rsp_rdata_d = rsp_rdata;
`ifdef RAM_INITIATOR_VERIFY_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lat_we_d    = req_we;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = req_we;
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                end
            end
            ISSUE: begin
                if (lat_we_q) begin
`ifdef RAM_INITIATOR_VERIFY_EN
                    mem_ce_d    = 1'b1;
`else
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = 1'b1;
                    rsp_rdata_d = '0;
`endif
                end
            end
            WAIT: begin
                rsp_valid_d = 1'b1;
                rsp_we_d    = 1'b0;
                rsp_rdata_d = mem_rdata;
`ifdef RAM_INITIATOR_VERIFY_EN
                rsp_err_d   = 1'b0;
`endif
            end
`ifdef RAM_INITIATOR_VERIFY_EN
            VWAIT: begin
                rsp_valid_d = 1'b1;
                rsp_we_d    = 1'b1;
                rsp_rdata_d = mem_rdata;
                rsp_err_d   = (mem_rdata != lat_wdata_q);
            end
`endif
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
`ifdef RAM_INITIATOR_VERIFY_EN
                    rsp_err_d   = 1'b0;
`endif
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_initiator.sv
// Scoreboard bench for ram_initiator driving a behavioural synchronous RAM.
module tb_ram_initiator;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
`ifdef RAM_INITIATOR_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic              clk, rst;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic              mem_ce, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    logic [DATA_W-1:0] ram [256];
    logic [DATA_W-1:0] ram_dout;
    logic              force_zero;

    ram_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_dout      <= ram[mem_addr];
        end
    end
    assign mem_rdata = force_zero ? '0 : ram_dout;

    typedef struct {
        logic              we;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;
    exp_t sb_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every accepted response is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            exp_t e;
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("rsp_we", rsp_we, e.we);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", rsp_err, e.err);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rdata, input logic exp_err, input int exp_lat);
        int lat;
        wait_ready();
        sb_q.push_back('{we, exp_rdata, exp_err});
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
        check("issue_ce", mem_ce, 1);
        check("issue_we", mem_we, we);
        check("issue_addr", mem_addr, addr);
        check("issue_wdata", mem_wdata, wdata);
        check("req_ready_busy", req_ready, 0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) check("ce_after_issue", mem_ce, we && VERIFY);
        end while (!rsp_valid && lat < 10);
        check("latency", lat, exp_lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; force_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_mem_ce", mem_ce, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_req_ready", req_ready, 1);

        do_req(1'b1, 8'h05, 8'h3C, VERIFY ? 8'h3C : 8'h00, 1'b0, VERIFY ? 3 : 1);
        do_req(1'b0, 8'h05, 8'h00, 8'h3C, 1'b0, 2);
        do_req(1'b1, 8'hFF, 8'hA5, VERIFY ? 8'hA5 : 8'h00, 1'b0, VERIFY ? 3 : 1);
        do_req(1'b1, 8'h00, 8'h11, VERIFY ? 8'h11 : 8'h00, 1'b0, VERIFY ? 3 : 1);
        do_req(1'b0, 8'hFF, 8'h00, 8'hA5, 1'b0, 2);
        do_req(1'b0, 8'h00, 8'h00, 8'h11, 1'b0, 2);

        // Back-pressure on a read; a stray request must be ignored.
        wait_ready();
        rsp_ready = 1'b0;
        sb_q.push_back('{1'b0, 8'h3C, 1'b0});
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp_rsp_valid", rsp_valid, 1);
        for (int k = 0; k < 3; k++) begin
            req_valid = (k == 0); req_we = 1'b1; req_addr = 8'h00; req_wdata = 8'h77;
            @(posedge clk); #1;
            req_valid = 1'b0;
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_rdata", rsp_rdata, 8'h3C);
            check("bp_req_ready", req_ready, 0);
            check("bp_mem_ce", mem_ce, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", req_ready, 1);
        check("bp_release_valid", rsp_valid, 0);
        do_req(1'b0, 8'h00, 8'h00, 8'h11, 1'b0, 2);

        // Reset during WAIT of a read aborts it.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_mem_ce", mem_ce, 0);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_mem_wdata", mem_wdata, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_rsp_rdata", rsp_rdata, 0);
        check("abort_req_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_ready_after", req_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("abort_no_rsp", rsp_valid, 0);
        end

`ifdef RAM_INITIATOR_VERIFY_EN
        do_req(1'b1, 8'h07, 8'h3C, 8'h3C, 1'b0, 3);
        force_zero = 1'b1;
        do_req(1'b1, 8'h07, 8'h3C, 8'h00, 1'b1, 3);
        @(posedge clk); #1;
        force_zero = 1'b0;
        check("verify_err_clear", rsp_err, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/ram_initiator.md
Name: ram_initiator

Overview:
- Request-side master for the single-port synchronous RAM: the block that drives ce/we/addr_in/data_in and samples data_out.
- Accepts one read or write request at a time on a valid/ready handshake and sequences the RAM pins with correct timing.
- Returns a response, carrying read data for reads, on a second valid/ready handshake.
- Sits between a CPU/DMA-style requester and the RAM instance.

Parameters:
- ADDR_W, 8, width of request and memory address.
- DATA_W, 8, width of write/read data.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  request address
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts response
- rsp_we  output  1  echo of the completed op type
- rsp_rdata  output  DATA_W  read data (0 for writes)
- rsp_err  output  1  read-back mismatch flag (see Optional Feature)
- mem_ce  output  1  RAM chip enable
- mem_we  output  1  RAM write enable
- mem_addr  output  ADDR_W  RAM address
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM data_out; registered by RAM one edge after a read enable

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - mem_ce, mem_we, mem_addr, mem_wdata = 0.
  - rsp_valid, rsp_we, rsp_rdata, rsp_err = 0.
  - req_ready = 0 while rst is high.
- req_ready = 1 only in IDLE with rst low. It is driven combinationally from state, never from req_valid.
- All mem_* and rsp_* outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP. VRD and VWAIT exist only with the macro.
- IDLE:
  - On req_valid && req_ready at edge E0: latch req_we, req_addr, req_wdata.
  - Same edge: drive mem_ce=1, mem_we=req_we, mem_addr=req_addr, mem_wdata=req_wdata.
  - Go to ISSUE.
- ISSUE: exactly one cycle with mem_ce=1; the RAM acts at edge E1. At E1:
  - mem_ce=0, mem_we=0.
  - Write: rsp_valid=1, rsp_we=1, rsp_rdata=0, go to RESP.
  - Read: go to WAIT.
- WAIT (reads only): mem_rdata is valid during this cycle. At E2:
  - rsp_rdata=mem_rdata, rsp_we=0, rsp_valid=1.
  - Go to RESP.
- RESP: hold rsp_* stable while rsp_ready=0. On rsp_valid && rsp_ready:
  - rsp_valid=0, go to IDLE.
  - The next request is accepted no earlier than the following cycle, so there is no same-cycle turnaround.
- Latency, accept edge to rsp_valid high: write 1 cycle, read 2 cycles. Throughput is one transaction per 3 cycles (write) or 4 cycles (read) with rsp_ready tied high.
- mem_addr and mem_wdata hold their last values when mem_ce=0. mem_we is 0 whenever mem_ce=0.
- req_* inputs are ignored outside IDLE. Changes to them after acceptance do not affect the transaction in flight.
- Every address 0..2^ADDR_W-1 is legal. There is no wrap or increment logic.
- Reset asserted mid-transaction aborts it:
  - mem_ce drops asynchronously and no response is produced.
  - A write in ISSUE may or may not land in the RAM, since the RAM is synchronous.

Optional Feature:
- Macro: RAM_INITIATOR_VERIFY_EN.
- Defined:
  - After a write's ISSUE, the FSM goes to VRD: one cycle of mem_ce=1, mem_we=0, same mem_addr.
  - Then VWAIT. At the following edge: rsp_rdata=mem_rdata, rsp_err=(mem_rdata != latched wdata), rsp_valid=1, rsp_we=1.
  - Write latency becomes 3 cycles.
  - Reads are unchanged, with rsp_err=0.
  - rsp_err clears together with rsp_valid.
- Undefined:
  - VRD and VWAIT states are absent.
  - rsp_err is tied to 0.
  - Timing is as in Behaviour.

Test Plan:
- Reset, then write addr 0x05 data 0x3C with rsp_ready=1 -> mem_ce high exactly 1 cycle with mem_we=1, mem_addr=0x05, mem_wdata=0x3C. rsp_valid rises 1 cycle after accept, rsp_we=1, rsp_rdata=0x00.
- Read addr 0x05 -> mem_ce high 1 cycle with mem_we=0. rsp_valid rises 2 cycles after accept with rsp_rdata=0x3C, rsp_we=0.
- Write 0xA5 to 0xFF and 0x11 to 0x00, then read both -> 0xA5 and 0x11 (full address range, no aliasing).
- Read with rsp_ready held 0 for 3 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, and a req_valid pulse is ignored. Raising rsp_ready -> req_ready=1 the next cycle.
- Assert rst during WAIT of a read -> all outputs 0 immediately, no rsp_valid after release, req_ready=1 in the first cycle after rst drops.
- With RAM_INITIATOR_VERIFY_EN:
  - Write 0x3C to 0x07 -> rsp after 3 cycles, rsp_rdata=0x3C, rsp_err=0.
  - Repeat with the bench forcing mem_rdata=0x00 during VWAIT -> rsp_err=1.
